// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite to APB bridge: one AHB slave port fanned out to NUM_SLOTS APB slots.
// Optional macro: APB_TIMEOUT_EN (ACCESS-phase watchdog, TIMEOUT_CYC cycles).
//
// Ports:
//   HCLK, HRESETN                    clock, async active-low reset
//   HSEL/HADDR/HWRITE/HTRANS/HSIZE   AHB address phase (HSIZE ignored)
//   HWDATA, HREADYIN                 AHB write data, bus ready
//   HREADYOUT/HRESP/HRDATA           AHB response (all registered)
//   PSEL[NUM_SLOTS]/PADDR/PWRITE/    APB request (all registered)
//   PENABLE/PWDATA
//   PRDATA/PREADY/PSLVERR            APB response, pre-muxed from selected slave
module ahbl_apb_bridge #(
    parameter int NUM_SLOTS   = 16,
    parameter int SLOT_ABIT   = 24,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 HCLK,
    input  logic                 HRESETN,
    input  logic                 HSEL,
    input  logic [31:0]          HADDR,
    input  logic                 HWRITE,
    input  logic [1:0]           HTRANS,
    input  logic [2:0]           HSIZE,
    input  logic [31:0]          HWDATA,
    input  logic                 HREADYIN,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [31:0]          HRDATA,
    output logic [NUM_SLOTS-1:0] PSEL,
    output logic [31:0]          PADDR,
    output logic                 PWRITE,
    output logic                 PENABLE,
    output logic [31:0]          PWDATA,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_e;

    // Slave-local address: bits below the slot field
    localparam logic [31:0] LOW_MASK = (32'h1 << SLOT_ABIT) - 32'h1;
    localparam logic [7:0]  TO_LIM   = 8'(TIMEOUT_CYC);

    state_e                 state_q;
    logic [31:0]            addr_q;
    logic [3:0]             slot_q;
    logic                   write_q;
    logic                   hready_q;
    logic                   hresp_q;
    logic [31:0]            hrdata_q;
    logic [NUM_SLOTS-1:0]   psel_q;
    logic [31:0]            paddr_q;
    logic                   pwrite_q;
    logic                   penable_q;
    logic [31:0]            pwdata_q;
`ifdef APB_TIMEOUT_EN
    logic [7:0]             to_q;
`endif

    logic                   accept;
    logic                   slot_ok;
    logic [15:0]            onehot;

    // NONSEQ/SEQ only; IDLE and BUSY transfers are dropped
    assign accept  = HSEL & HREADYIN & HTRANS[1];
    assign slot_ok = ({1'b0, slot_q} < 5'(NUM_SLOTS));
    assign onehot  = 16'd1 << slot_q;

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            slot_q    <= '0;
            write_q   <= 1'b0;
            hready_q  <= 1'b1;
            hresp_q   <= 1'b0;
            hrdata_q  <= '0;
            psel_q    <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            pwdata_q  <= '0;
`ifdef APB_TIMEOUT_EN
            to_q      <= '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        addr_q   <= HADDR & LOW_MASK;
                        slot_q   <= HADDR[SLOT_ABIT+:4];
                        write_q  <= HWRITE;
                        hready_q <= 1'b0;
                        state_q  <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    // HWDATA is valid in the data phase, i.e. this cycle
                    pwdata_q <= HWDATA;
                    if (slot_ok) begin
                        psel_q   <= onehot[NUM_SLOTS-1:0];
                        paddr_q  <= addr_q;
                        pwrite_q <= write_q;
                        state_q  <= S_SETUP;
                    end else begin
                        hresp_q  <= 1'b1;
                        state_q  <= S_ERR1;
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    to_q      <= '0;
`endif
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        if (PSLVERR) begin
                            hresp_q <= 1'b1;
                            state_q <= S_ERR1;
                        end else begin
                            hready_q <= 1'b1;
                            if (!pwrite_q) begin
                                hrdata_q <= PRDATA;
                            end
                            state_q  <= S_IDLE;
                        end
                    end
`ifdef APB_TIMEOUT_EN
                    else begin
                        to_q <= to_q + 8'd1;
                        if (to_q + 8'd1 == TO_LIM) begin
                            psel_q    <= '0;
                            penable_q <= 1'b0;
                            hresp_q   <= 1'b1;
                            state_q   <= S_ERR1;
                        end
                    end
`endif
                end
                S_ERR1: begin
                    // Second half of the two-cycle AHB error response
                    hready_q <= 1'b1;
                    state_q  <= S_ERR2;
                end
                S_ERR2: begin
                    hresp_q <= 1'b0;
                    if (accept) begin
                        addr_q   <= HADDR & LOW_MASK;
                        slot_q   <= HADDR[SLOT_ABIT+:4];
                        write_q  <= HWRITE;
                        hready_q <= 1'b0;
                        state_q  <= S_LATCH;
                    end else begin
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign HREADYOUT = hready_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;
    assign PSEL      = psel_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PENABLE   = penable_q;
    assign PWDATA    = pwdata_q;

    logic unused_ok;
    assign unused_ok = ^{HSIZE, HTRANS[0], onehot, TO_LIM};

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// Directed bench for ahbl_apb_bridge (NUM_SLOTS=4, SLOT_ABIT=24).
// Inputs driven and outputs sampled on the falling edge of HCLK.
module tb_ahbl_apb_bridge;

    logic        HCLK;
    logic        HRESETN;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADYIN;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [3:0]  PSEL;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    ahbl_apb_bridge #(
        .NUM_SLOTS   (4),
        .SLOT_ABIT   (24),
        .TIMEOUT_CYC (255)
    ) dut (
        .HCLK      (HCLK),
        .HRESETN   (HRESETN),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADYIN  (HREADYIN),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PSEL      (PSEL),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PENABLE   (PENABLE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Results recorded by ahb_xfer
    int          lowcnt;
    logic [3:0]  psel_seen;
    logic [31:0] paddr_s;
    logic [31:0] pwdata_s;
    logic        pwrite_s;
    logic        hresp_low;
    logic        hresp_end;
    logic        tmo;

    // Called on a falling edge; returns on the falling edge where
    // HREADYOUT is seen high again. Models a single APB slave.
    task automatic ahb_xfer(input logic [31:0] a, input logic w,
                            input logic [31:0] wd, input int waits,
                            input logic [31:0] rd, input logic err);
        int acc;
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = a;
        HWRITE = w;
        @(negedge HCLK);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HADDR  = '0;
        HWDATA = wd;
        lowcnt    = 0;
        acc       = 0;
        psel_seen = '0;
        hresp_low = 1'b0;
        tmo       = 1'b0;
        while (HREADYOUT == 1'b0) begin
            lowcnt++;
            hresp_low = HRESP;
            if (PSEL != '0) begin
                psel_seen = psel_seen | PSEL;
                paddr_s   = PADDR;
                pwdata_s  = PWDATA;
                pwrite_s  = PWRITE;
            end
            if (PSEL != '0 && PENABLE) begin
                PREADY  = (acc >= waits);
                PSLVERR = err && PREADY;
                PRDATA  = rd;
                acc++;
            end else begin
                PREADY  = 1'b0;
                PSLVERR = 1'b0;
            end
            if (lowcnt > 50) begin
                tmo = 1'b1;
                break;
            end
            @(negedge HCLK);
        end
        hresp_end = HRESP;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        check("xfer_done", 32'(tmo), 32'd0);
    endtask

    int t0;

    initial begin
        HRESETN  = 1'b0;
        HSEL     = 1'b0;
        HADDR    = '0;
        HWRITE   = 1'b0;
        HTRANS   = 2'b00;
        HSIZE    = 3'd2;
        HWDATA   = '0;
        HREADYIN = 1'b1;
        PRDATA   = '0;
        PREADY   = 1'b0;
        PSLVERR  = 1'b0;
        repeat (3) @(negedge HCLK);

        check("rst_hready", 32'(HREADYOUT), 32'd1);
        check("rst_hresp",  32'(HRESP),     32'd0);
        check("rst_psel",   32'(PSEL),      32'd0);
        check("rst_hrdata", HRDATA,         32'd0);
        check("rst_paddr",  PADDR,          32'd0);
        HRESETN = 1'b1;
        @(negedge HCLK);

        // Zero-wait write to slot 3
        ahb_xfer(32'h0300_0010, 1'b1, 32'hA5A5_5A5A, 0, 32'h0, 1'b0);
        check("wr_low",    32'(lowcnt),    32'd3);
        check("wr_psel",   32'(psel_seen), 32'h8);
        check("wr_paddr",  paddr_s,        32'h10);
        check("wr_pwdata", pwdata_s,       32'hA5A5_5A5A);
        check("wr_pwrite", 32'(pwrite_s),  32'd1);
        check("wr_hresp",  32'(hresp_end), 32'd0);

        // Read from slot 1 with two wait states
        ahb_xfer(32'h0100_0004, 1'b0, 32'h0, 2, 32'h1234_5678, 1'b0);
        check("rd_low",    32'(lowcnt),    32'd5);
        check("rd_psel",   32'(psel_seen), 32'h2);
        check("rd_paddr",  paddr_s,        32'h4);
        check("rd_pwrite", 32'(pwrite_s),  32'd0);
        check("rd_hrdata", HRDATA,         32'h1234_5678);

        // Write answered with PSLVERR
        ahb_xfer(32'h0200_0020, 1'b1, 32'h5555_AAAA, 0, 32'h0, 1'b1);
        check("slverr_low",   32'(lowcnt),    32'd4);
        check("slverr_err1",  32'(hresp_low), 32'd1);
        check("slverr_err2",  32'(hresp_end), 32'd1);
        @(negedge HCLK);
        check("slverr_idle",  32'(HRESP),     32'd0);
        check("slverr_psel",  32'(PSEL),      32'd0);

        // Failing read leaves HRDATA alone
        ahb_xfer(32'h0000_0008, 1'b0, 32'h0, 1, 32'hDEAD_BEEF, 1'b1);
        check("rderr_resp",   32'(hresp_end), 32'd1);
        check("rderr_hrdata", HRDATA,         32'h1234_5678);
        @(negedge HCLK);

        // Slot 5 does not exist with four slots
        ahb_xfer(32'h0500_0000, 1'b1, 32'h0, 0, 32'h0, 1'b0);
        check("oor_low",  32'(lowcnt),    32'd2);
        check("oor_psel", 32'(psel_seen), 32'h0);
        check("oor_err1", 32'(hresp_low), 32'd1);
        check("oor_err2", 32'(hresp_end), 32'd1);
        @(negedge HCLK);

        // Back-to-back: four clocks per transfer, no gap
        t0 = cyc;
        ahb_xfer(32'h0000_0100, 1'b1, 32'h0BAD_F00D, 0, 32'h0, 1'b0);
        ahb_xfer(32'h0300_0044, 1'b0, 32'h0, 0, 32'hCAFE_F00D, 1'b0);
        check("b2b_cycles", 32'(cyc - t0), 32'd8);
        check("b2b_hrdata", HRDATA,        32'hCAFE_F00D);
        check("b2b_paddr",  paddr_s,       32'h44);

        // Slave never ready: bus stays stalled
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = 32'h0200_0040;
        HWRITE = 1'b0;
        @(negedge HCLK);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        PREADY = 1'b0;
        repeat (100) @(negedge HCLK);
        check("stall_hready",  32'(HREADYOUT), 32'd0);
        check("stall_psel",    32'(PSEL),      32'h4);
        check("stall_penable", 32'(PENABLE),   32'd1);

        // Asynchronous reset in the middle of ACCESS
        #2 HRESETN = 1'b0;
        #1;
        check("arst_psel",    32'(PSEL),      32'd0);
        check("arst_penable", 32'(PENABLE),   32'd0);
        check("arst_hready",  32'(HREADYOUT), 32'd1);
        check("arst_hresp",   32'(HRESP),     32'd0);
        check("arst_hrdata",  HRDATA,         32'd0);
        @(negedge HCLK);
        HRESETN = 1'b1;

        ahb_xfer(32'h0100_0008, 1'b1, 32'h0F0F_0F0F, 0, 32'h0, 1'b0);
        check("post_low",    32'(lowcnt),    32'd3);
        check("post_psel",   32'(psel_seen), 32'h2);
        check("post_pwdata", pwdata_s,       32'h0F0F_0F0F);
        check("post_hresp",  32'(hresp_end), 32'd0);

        repeat (2) @(negedge HCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/ahbl_apb_bridge.md
AHBL_APB_BRIDGE -- requirements
Module: ahbl_apb_bridge

Interface
REQ-001 Parameter NUM_SLOTS, default 16, number of APB slots/PSEL lines (legal 1..16).
REQ-002 Parameter SLOT_ABIT, default 24, LSB of the 4-bit slot field HADDR[SLOT_ABIT+3:SLOT_ABIT] (legal 2..28).
REQ-003 Parameter TIMEOUT_CYC, default 255, ACCESS-phase cycle limit, 8-bit, legal 1..255; used only with APB_TIMEOUT_EN.
REQ-004 One clock, HCLK; reset HRESETN is asynchronous, active-low; ports listed as: name  direction  width  meaning.
REQ-005 HCLK  in  1  clock; HRESETN  in  1  async active-low reset.
REQ-006 HSEL  in  1  bridge select; HADDR  in  32  address; HWRITE  in  1  write; HTRANS  in  2  transfer type; HSIZE  in  3  size (ignored).
REQ-007 HWDATA  in  32  write data; HREADYIN  in  1  bus ready; HREADYOUT  out  1  bridge ready; HRESP  out  1  error; HRDATA  out  32  read data.
REQ-008 PSEL  out  NUM_SLOTS  one-hot slot select; PADDR  out  32  address; PWRITE  out  1; PENABLE  out  1; PWDATA  out  32.
REQ-009 PRDATA  in  32, PREADY  in  1, PSLVERR  in  1: already muxed from the selected slave.

Function
REQ-010 FSM states IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2; all outputs registered.
REQ-011 IDLE and ERR2 accept a transfer when HSEL & HREADYIN & HTRANS[1]; capture HADDR, HWRITE; next state LATCH; HTRANS IDLE/BUSY ignored.
REQ-012 LATCH: HREADYOUT=0; capture HWDATA into PWDATA; slot<NUM_SLOTS -> SETUP, else -> ERR1 with no PSEL asserted.
REQ-013 SETUP: PSEL[slot]=1, PENABLE=0, PADDR={zeros, HADDR[SLOT_ABIT-1:0]}, PWRITE=captured HWRITE; one cycle, then ACCESS.
REQ-014 ACCESS: PSEL[slot]=1, PENABLE=1; held while PREADY=0; PADDR/PWDATA/PWRITE stable through SETUP and ACCESS.
REQ-015 ACCESS & PREADY & !PSLVERR -> IDLE; reads capture PRDATA into HRDATA; PSEL/PENABLE deassert next cycle.
REQ-016 ACCESS & PREADY & PSLVERR -> ERR1; HRDATA unchanged.
REQ-017 ERR1: HREADYOUT=0, HRESP=1; ERR2: HREADYOUT=1, HRESP=1; then IDLE unless a new transfer is accepted in ERR2.
REQ-018 IDLE: HREADYOUT=1, HRESP=0, HRDATA holds last captured value.
REQ-019 Zero-wait-state slave: HREADYOUT low for exactly 3 cycles (LATCH, SETUP, ACCESS) per transfer; back-to-back transfers have no idle cycle between them.

Reset
REQ-020 HRESETN low forces IDLE asynchronously, mid-transfer included: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, timeout counter=0.
REQ-021 The first transfer may be accepted on the first HCLK rising edge after HRESETN deasserts.

Configuration
REQ-022 With APB_TIMEOUT_EN defined, a counter clears on ACCESS entry and increments each ACCESS cycle with PREADY=0.
REQ-023 When the count reaches TIMEOUT_CYC, the bridge drops PSEL/PENABLE next cycle and enters ERR1.
REQ-024 Without APB_TIMEOUT_EN, no counter is built and ACCESS waits on PREADY indefinitely.

Verification
REQ-025 Write 0x0300_0010 data 0xA5A5_5A5A, PREADY=1 -> PSEL=0x0008, PADDR=0x10, PWDATA=0xA5A5_5A5A; HREADYOUT low 3 cycles, HRESP=0.
REQ-026 Read 0x0100_0004, PREADY low 2 cycles, PRDATA=0x1234_5678 -> HREADYOUT low 5 cycles, HRDATA=0x1234_5678.
REQ-027 Write with PSLVERR=1 at PREADY -> two-cycle ERR1/ERR2 response; HRESP=1 both cycles, HREADYOUT 0 then 1.
REQ-028 NUM_SLOTS=4, access 0x0500_0000 -> PSEL stays 0, ERR1/ERR2 response.
REQ-029 APB_TIMEOUT_EN, TIMEOUT_CYC=8, PREADY stuck 0 -> PSEL drops after 8 ACCESS cycles, error response; without macro, bus still stalled at 100 cycles.
REQ-030 HRESETN low during ACCESS -> PSEL/PENABLE 0 and HREADYOUT 1 before the next HCLK edge; next transfer completes normally.
